// File: rtl/pipe_retire_tracker.sv
// pipe_retire_tracker
//
// Follows instruction occupancy through a STAGES-deep in-order pipeline and
// reports retirement and drain status to the instruction-stepping control.
//
// Parameters:
//   STAGES        number of pipeline stages (>= 2)
//   FLUSH_STAGES  leading stages killed by flush (1 .. STAGES-1)
//   CNT_W         width of the retired-instruction counter
//
// Ports:
//   clk                 system clock, rising-edge
//   rst                 asynchronous active-low reset
//   instr_fetch_enable  one instruction enters stage 0 this cycle
//   stall               freeze every stage; a fetch offered while stalled is lost
//   flush               kill instructions in stages 0..FLUSH_STAGES-1
//   stage_valid         bit i set when stage i holds a live instruction
//   inflight_count      popcount of stage_valid
//   retire              pulse: an instruction left the last stage at the previous edge
//   retired_count       running total of retired instructions, wraps silently
//   instr_completed     pipeline empty
module pipe_retire_tracker #(
    parameter int unsigned STAGES       = 5,
    parameter int unsigned FLUSH_STAGES = 2,
    parameter int unsigned CNT_W        = 32,
    localparam int unsigned IC_W        = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_fetch_enable,
    input  logic              stall,
    input  logic              flush,
    output logic [STAGES-1:0] stage_valid,
    output logic [IC_W-1:0]   inflight_count,
    output logic              retire,
    output logic [CNT_W-1:0]  retired_count,
    output logic              instr_completed
);

    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] v_shift;
    logic              retire_q, retire_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [IC_W-1:0]   popcount;

    // Fetch lands in stage 0, everything else moves up one stage.
    assign v_shift = {v_q[STAGES-2:0], instr_fetch_enable};

    // Priority: flush > stall > advance.
    always_comb begin
        v_d      = v_q;
        retire_d = 1'b0;
        count_d  = count_q;
        if (flush && !stall) begin
            v_d = v_shift;
            // Clearing stage FLUSH_STAGES too drops the killed instruction that
            // was moving out of the last flushed stage.
            for (int i = 0; i <= int'(FLUSH_STAGES); i++) begin
                v_d[i] = 1'b0;
            end
            retire_d = v_q[STAGES-1];
            count_d  = count_q + CNT_W'(v_q[STAGES-1]);
        end else if (flush && stall) begin
            // Front stages die in place; the rest stays frozen.
            for (int i = 0; i < int'(FLUSH_STAGES); i++) begin
                v_d[i] = 1'b0;
            end
        end else if (!stall) begin
            v_d      = v_shift;
            retire_d = v_q[STAGES-1];
            count_d  = count_q + CNT_W'(v_q[STAGES-1]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q      <= '0;
            retire_q <= 1'b0;
            count_q  <= '0;
        end else begin
            v_q      <= v_d;
            retire_q <= retire_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        popcount = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            popcount = popcount + IC_W'(v_q[i]);
        end
    end

    assign stage_valid     = v_q;
    assign inflight_count  = popcount;
    assign retire          = retire_q;
    assign retired_count   = count_q;
    assign instr_completed = (v_q == '0);

endmodule
